// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order imem requests for the current PC and
// buffers {pc, instr} pairs in a DEPTH-entry queue for decode; a jump flushes it.
module instr_fetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_ready,
  input  logic        j_signal,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [PTR_W-1:0] alloc_ptr_next, fill_ptr_next, head_ptr_next;
  // pend_cnt: allocated entries still waiting for their response
  logic [CNT_W-1:0] alloc_cnt, pend_cnt, drop_cnt;
  logic [CNT_W-1:0] alloc_cnt_next, pend_cnt_next, drop_cnt_next;

  logic [SUM_W-1:0] owed;
  logic             req_hs;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;

  // Request credit covers both live entries and responses still owed for flushed requests.
  assign owed           = SUM_W'(alloc_cnt) + SUM_W'(drop_cnt);
  assign imem_req_valid = !reset && !j_signal && (owed < SUM_W'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign pc_ready       = imem_req_valid && imem_req_ready;

  assign id_valid = filled[head_ptr] && !j_signal;
  assign id_pc    = pc_q[head_ptr];
  assign id_instr = instr_q[head_ptr];

  assign req_hs   = pc_ready;
  assign pop      = id_valid && id_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt != CNT_W'(0));
  assign rsp_fill = imem_rsp_valid && (drop_cnt == CNT_W'(0)) && !j_signal;

  // Next-state for pointers and counters; a flush overrides everything else.
  always_comb begin
    alloc_ptr_next = alloc_ptr;
    fill_ptr_next  = fill_ptr;
    head_ptr_next  = head_ptr;
    alloc_cnt_next = alloc_cnt;
    pend_cnt_next  = pend_cnt;
    drop_cnt_next  = drop_cnt;
    if (j_signal) begin
      alloc_ptr_next = '0;
      fill_ptr_next  = '0;
      head_ptr_next  = '0;
      alloc_cnt_next = '0;
      pend_cnt_next  = '0;
      drop_cnt_next  = drop_cnt + pend_cnt - CNT_W'(imem_rsp_valid);
    end else begin
      alloc_ptr_next = alloc_ptr + PTR_W'(req_hs);
      fill_ptr_next  = fill_ptr + PTR_W'(rsp_fill);
      head_ptr_next  = head_ptr + PTR_W'(pop);
      alloc_cnt_next = alloc_cnt + CNT_W'(req_hs) - CNT_W'(pop);
      pend_cnt_next  = pend_cnt + CNT_W'(req_hs) - CNT_W'(rsp_fill);
      drop_cnt_next  = drop_cnt - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      alloc_ptr <= alloc_ptr_next;
      fill_ptr  <= fill_ptr_next;
      head_ptr  <= head_ptr_next;
      alloc_cnt <= alloc_cnt_next;
      pend_cnt  <= pend_cnt_next;
      drop_cnt  <= drop_cnt_next;
    end
  end

  // Entry storage: pop clears, allocation writes pc, fill writes instr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filled <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[PTR_W'(i)]    <= '0;
        instr_q[PTR_W'(i)] <= '0;
      end
    end else if (j_signal) begin
      filled <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[PTR_W'(i)]    <= '0;
        instr_q[PTR_W'(i)] <= '0;
      end
    end else begin
      if (pop) begin
        filled[head_ptr] <= 1'b0;
      end
      if (req_hs) begin
        pc_q[alloc_ptr]   <= pc_in;
        filled[alloc_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        instr_q[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-level reference model plus PC stage and in-order
// memory models, directed scenarios followed by randomized traffic.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, j_signal, imem_req_ready, imem_rsp_valid, id_ready;
  logic        pc_ready, imem_req_valid, id_valid;
  logic [31:0] pc_in, imem_req_addr, imem_rsp_data, id_pc, id_instr;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .pc_ready      (pc_ready),
    .j_signal      (j_signal),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_ready      (id_ready)
  );

  typedef struct {logic [31:0] pc; logic [31:0] instr; bit filled;} ent_t;
  typedef struct {logic [31:0] pc; int due;} mreq_t;

  ent_t        live[$];     // current-epoch fetches, oldest first
  int          stale;       // responses owed for flushed requests
  mreq_t       mq[$];       // memory's outstanding requests
  logic [31:0] pc_reg;
  int          cyc;

  int checks = 0;
  int failures = 0;

  int unsigned lat_min, lat_max, p_req_ready, p_id_ready, p_jump, p_reset;
  int          rst_cycles;
  bit          force_jump;
  logic [31:0] jump_target;

  bit          e_req_valid, e_id_valid;
  logic [31:0] e_id_pc, e_id_instr;

  int          dut_hs, first_hs, first_idv;
  logic [31:0] del_pc[$];
  logic [31:0] del_instr[$];
  int          del_cyc[$];
  int          drop_hist[$];
  bit          idv_hist[$];

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unfilled();
    int n = 0;
    foreach (live[i]) if (!live[i].filled) n++;
    return n;
  endfunction

  task automatic compute_exp();
    if (reset) begin
      e_req_valid = 1'b0;
      e_id_valid  = 1'b0;
      e_id_pc     = '0;
      e_id_instr  = '0;
    end else begin
      e_req_valid = !j_signal && (live.size() + stale < DEPTH);
      e_id_valid  = !j_signal && live.size() > 0 && live[0].filled;
      e_id_pc     = (live.size() > 0) ? live[0].pc : 32'd0;
      e_id_instr  = (live.size() > 0) ? live[0].instr : 32'd0;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    compute_exp();
    chk("req_valid", 32'(imem_req_valid), 32'(e_req_valid));
    chk("pc_ready", 32'(pc_ready), 32'(e_req_valid && imem_req_ready));
    chk("req_addr", imem_req_addr, pc_reg);
    chk("id_valid", 32'(id_valid), 32'(e_id_valid));
    if (reset || e_id_valid) begin
      chk("id_pc", id_pc, e_id_pc);
      chk("id_instr", id_instr, e_id_instr);
    end
    chk("drop_cnt", 32'(dut.drop_cnt), reset ? 32'd0 : 32'(stale));
    if (!reset) begin
      if (pc_ready) begin
        dut_hs++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (id_valid && first_idv < 0) first_idv = cyc;
      if (id_valid && id_ready) begin
        del_pc.push_back(id_pc);
        del_instr.push_back(id_instr);
        del_cyc.push_back(cyc);
      end
    end
    drop_hist.push_back(int'(dut.drop_cnt));
    idv_hist.push_back(id_valid);
  endtask

  task automatic update();
    bit    req_hs, pop;
    int    k;
    ent_t  e;
    mreq_t m;
    req_hs = e_req_valid && imem_req_ready;
    pop    = e_id_valid && id_ready;
    if (reset) begin
      live.delete();
      mq.delete();
      stale  = 0;
      pc_reg = '0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (j_signal) begin
        stale  = stale + unfilled() - int'(imem_rsp_valid);
        live.delete();
        pc_reg = jump_target;
      end else begin
        if (imem_rsp_valid) begin
          if (stale > 0) stale--;
          else begin
            k = -1;
            foreach (live[i]) if (k < 0 && !live[i].filled) k = i;
            if (k < 0) chk("rsp_unowed", 32'd1, 32'd0);
            else begin
              live[k].instr  = imem_rsp_data;
              live[k].filled = 1'b1;
            end
          end
        end
        if (pop) void'(live.pop_front());
        if (req_hs) begin
          e.pc = pc_reg; e.instr = '0; e.filled = 1'b0;
          live.push_back(e);
          m.pc  = pc_reg;
          m.due = cyc + int'($urandom_range(lat_max, lat_min));
          mq.push_back(m);
          pc_reg = pc_reg + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic drive();
    if (p_reset > 0 && rst_cycles == 0 && $urandom_range(999, 0) < p_reset) rst_cycles = 2;
    reset = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    pc_in          = pc_reg;
    imem_req_ready = ($urandom_range(99, 0) < p_req_ready);
    id_ready       = ($urandom_range(99, 0) < p_id_ready);
    j_signal       = !reset && (force_jump || $urandom_range(99, 0) < p_jump);
    if (force_jump) jump_target = 32'h100;
    else begin
      jump_target      = $urandom();
      jump_target[1:0] = 2'b00;
    end
    force_jump = 1'b0;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].pc);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
    drive();
  endtask

  task automatic clear_obs();
    del_pc.delete(); del_instr.delete(); del_cyc.delete();
    drop_hist.delete(); idv_hist.delete();
    dut_hs = 0; first_hs = -1; first_idv = -1;
  endtask

  task automatic set_knobs(input int unsigned lmin, input int unsigned lmax,
                           input int unsigned preq, input int unsigned pid);
    lat_min = lmin; lat_max = lmax; p_req_ready = preq; p_id_ready = pid;
  endtask

  initial begin
    int n;
    reset = 1'b0; j_signal = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    id_ready = 1'b0; pc_in = '0; imem_rsp_data = '0;
    stale = 0; pc_reg = '0; cyc = 0; force_jump = 1'b0; jump_target = '0;
    p_jump = 0; p_reset = 0;
    set_knobs(1, 1, 100, 100);
    clear_obs();
    rst_cycles = 3;
    #1 drive();

    // Reset then steady stream at latency 1
    repeat (16) step();
    chk("first_idv_latency", 32'(first_idv - first_hs), 32'd2);
    chk("stream_len", 32'(del_pc.size() >= 6), 32'd1);
    if (del_pc.size() >= 6) begin
      chk("stream_pc0", del_pc[0], 32'h0);
      chk("stream_instr0", del_instr[0], 32'h5A5A5A5A);
      chk("stream_pc1", del_pc[1], 32'h4);
      chk("stream_instr1", del_instr[1], 32'h2287BC9E);
      chk("stream_rate", 32'(del_cyc[5] - del_cyc[0]), 32'd5);
    end

    // Decode backpressure fills the queue, then drains in order
    set_knobs(1, 1, 100, 0);
    rst_cycles = 2;
    repeat (3) step();
    clear_obs();
    repeat (10) step();
    chk("bp_handshakes", 32'(dut_hs), 32'd4);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_pc_ready", 32'(pc_ready), 32'd0);
    p_id_ready = 100;
    clear_obs();
    repeat (10) step();
    chk("bp_drain_len", 32'(del_pc.size() >= 5), 32'd1);
    if (del_pc.size() >= 5)
      for (int i = 0; i < 5; i++) chk("bp_drain_pc", del_pc[i], 32'(4 * i));

    // Memory stall
    p_req_ready = 0;
    step();
    clear_obs();
    repeat (5) step();
    chk("stall_handshakes", 32'(dut_hs), 32'd0);
    p_req_ready = 100;
    repeat (10) step();

    // Flush with two requests outstanding at latency 3
    set_knobs(3, 3, 100, 100);
    rst_cycles = 2;
    repeat (3) step();
    clear_obs();
    n = 0;
    while (dut_hs < 1 && n < 10) begin step(); n++; end
    chk("flush2_hs_seen", 32'(dut_hs >= 1), 32'd1);
    force_jump = 1'b1;
    step();
    clear_obs();
    repeat (12) step();
    chk("flush2_drop_f", 32'(drop_hist[0]), 32'd0);
    chk("flush2_drop_f1", 32'(drop_hist[1]), 32'd2);
    chk("flush2_drop_f2", 32'(drop_hist[2]), 32'd1);
    chk("flush2_drop_f3", 32'(drop_hist[3]), 32'd0);
    chk("flush2_len", 32'(del_pc.size() >= 1), 32'd1);
    if (del_pc.size() >= 1) chk("flush2_first_pc", del_pc[0], 32'h100);

    // Flush coinciding with a response and a would-be pop, latency 2
    set_knobs(2, 2, 100, 100);
    rst_cycles = 2;
    repeat (3) step();
    repeat (8) step();
    force_jump = 1'b1;
    step();
    clear_obs();
    repeat (8) step();
    chk("flushc_idv", 32'(idv_hist[0]), 32'd0);
    chk("flushc_drop_f1", 32'(drop_hist[1]), 32'd1);
    chk("flushc_drop_f2", 32'(drop_hist[2]), 32'd0);
    chk("flushc_len", 32'(del_pc.size() >= 1), 32'd1);
    if (del_pc.size() >= 1) chk("flushc_first_pc", del_pc[0], 32'h100);

    // Asynchronous reset between edges in mid-stream
    set_knobs(1, 1, 100, 100);
    repeat (6) step();
    #2;
    chk("pre_rst_idv", 32'(id_valid), 32'd1);
    reset = 1'b1;
    rst_cycles = 3;
    #1;
    chk("async_rst_idv", 32'(id_valid), 32'd0);
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    clear_obs();
    repeat (10) step();
    chk("rst_restart_len", 32'(del_pc.size() >= 1), 32'd1);
    if (del_pc.size() >= 1) chk("rst_restart_pc", del_pc[0], 32'h0);

    // Randomized traffic
    set_knobs(1, 4, 75, 70);
    p_jump = 5;
    p_reset = 3;
    repeat (3000) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the program counter. Takes the current PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returning words with their PCs in a DEPTH-entry queue. It hands {pc, instr} pairs to decode over a second valid/ready handshake. A jump (`j_signal`) flushes all buffered and in-flight fetches; stale memory responses are counted and discarded.

## Interface
- `DEPTH`, 4, fetch queue entries; power of two, ≥2; also the limit on outstanding requests.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  32  current PC from the PC stage.
- `pc_ready`  out  1  the PC advances only in cycles where this is 1 (= request handshake).
- `j_signal`  in  1  jump/flush; same signal that loads the PC with the jump target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (= `pc_in`).
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response valid; responses arrive in request order, latency ≥1 cycle.
- `imem_rsp_data`  in  32  instruction word.
- `id_valid`  out  1  decode entry valid.
- `id_pc`  out  32  PC of the head entry.
- `id_instr`  out  32  instruction of the head entry.
- `id_ready`  in  1  decode accepts the entry.

## Operation
- Storage: DEPTH entries of {pc, instr, filled}, plus three pointers:
  - `alloc_ptr`: allocates an entry on each request handshake and writes its pc.
  - `fill_ptr`: writes instr and sets filled on each non-dropped response.
  - `head_ptr`: pops on decode handshake.
- `alloc_cnt`: entries allocated and not yet popped, 0..DEPTH.
- `drop_cnt`: responses still owed for flushed requests, 0..DEPTH.
- `imem_req_valid = !j_signal && (alloc_cnt + drop_cnt < DEPTH)`. Combinational; must not depend on `imem_req_ready`.
- `pc_ready = imem_req_valid && imem_req_ready`.
- Response handling:
  - If `drop_cnt > 0`, the response is discarded and `drop_cnt` decrements.
  - Otherwise it fills the entry at `fill_ptr`.
- `id_valid = filled[head_ptr] && !j_signal`; `id_pc`/`id_instr` come from the head entry.
- Flush (`j_signal = 1`) takes priority over everything that cycle:
  - No request issued and no pop.
  - All entries cleared; all pointers and `alloc_cnt` go to 0.
  - `drop_cnt_next = drop_cnt + (allocated-but-unfilled entries) − imem_rsp_valid`. A response arriving in the flush cycle is always discarded.
- Simultaneous request, response and pop in one non-flush cycle are all legal and take effect together: `alloc_cnt_next = alloc_cnt + req_hs − pop`.
- Pointers wrap modulo DEPTH.
- Behaviour is undefined if `imem_rsp_valid` is asserted with no request outstanding.

## Timing
- Reset, asynchronous, active-high, effective immediately:
  - All pointers, counters and filled bits go to 0; entry storage goes to 0.
  - `id_valid` = 0, `id_pc` = `id_instr` = 0, `drop_cnt` = 0.
  - `imem_req_valid` and `pc_ready` = 0 while `reset` is high.
- Reset mid-operation discards everything. Responses to pre-reset requests are not tracked; the memory is reset on the same signal.
- Latency:
  - Request handshake in cycle N; earliest response in N+1.
  - Filled entry is visible as `id_valid` in N+2.
- Throughput: 1 instruction/cycle with memory latency 1, `id_ready` held high and DEPTH ≥3.
- Flush cycle F: requests may resume in F+1 if `drop_cnt` permits. `pc_in` holds the jump target from F+1.

## Test plan
- Reset/stream: hold reset 3 cycles, release with PC from 0, memory latency 1, `id_ready` = 1 → outputs are 0 during reset; `id_pc` = 0,4,8,… with instr = mem[pc]; first `id_valid` 2 cycles after first handshake, then every cycle.
- Backpressure: `id_ready` = 0 with DEPTH = 4 → exactly 4 handshakes (pc 0..0xC), then `imem_req_valid` = 0 and `pc_ready` = 0. Raise `id_ready` → pc 0,4,8,0xC,0x10 delivered in order, none lost or duplicated.
- Memory stall: `imem_req_ready` = 0 for 5 cycles → `pc_ready` = 0 and `imem_req_addr` stable throughout; stream resumes without gaps in pc.
- Flush with 2 outstanding (latency 3): pulse `j_signal`, jump to 0x100 → the two stale responses are discarded, `drop_cnt` goes 2 → 0; the first `id_pc` after the flush is 0x100.
- Flush coincident with a response and with `id_valid`/`id_ready` high → `id_valid` = 0 that cycle, no pop; the response is dropped and `drop_cnt` is correct.
- Reset asserted mid-stream, asynchronously between edges → `id_valid` and `imem_req_valid` fall immediately; after release the stream restarts cleanly from the PC.
